psg_bus_regfile: RTL

- Chip-side responder for the AY-3-8910/YM2149 bus, on the opposite end from the CPU glue that drives BDIR/BC2/BC1.
- Decodes the 3-wire bus mode and latches the register address with chip-select qualification.
- Commits writes into the 16-entry PSG register file and serves read-back onto the tri-state data bus.
- Feeds the tone/noise/envelope generators with a flat register image and an envelope-restart strobe.

---
 rtl/psg_bus_regfile.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/psg_bus_regfile.sv
// AY-3-8910/YM2149 chip-side bus responder: BDIR/BC2/BC1 decode, address latch, 16-entry register file, read-back.
// Optional macro PSG_PORTIO_EN adds the two 8-bit I/O ports (R14/R15) with synchronised input read-back.

module psg_reg_cell #(
  parameter logic [7:0] MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= 8'h00;
    else if (we) q <= d & MASK;
  end
endmodule

module psg_bus_regfile #(
  parameter logic [3:0] ADDR_HI    = 4'h0,
  parameter logic [7:0] RESET_DOUT = 8'hFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [7:0]   da_i,
  output logic [7:0]   da_o,
  output logic         da_oe_n,
  input  logic         bdir,
  input  logic         bc2,
  input  logic         bc1,
  input  logic         a8,
  input  logic         a9_n,
  output logic [127:0] regs,
  output logic         env_restart
`ifdef PSG_PORTIO_EN
  ,
  input  logic [7:0]   ioa_i,
  input  logic [7:0]   iob_i,
  output logic [7:0]   ioa_o,
  output logic [7:0]   iob_o,
  output logic         ioa_oe,
  output logic         iob_oe
`endif
);

  typedef enum logic {IDLE, WPEND} wstate_t;

  // Unimplemented bits per register are masked at commit so they always read 0.
  function automatic logic [7:0] reg_mask(input int n);
    case (n)
      1, 3, 5, 13:  reg_mask = 8'h0F;
      6, 8, 9, 10:  reg_mask = 8'h1F;
      default:      reg_mask = 8'hFF;
    endcase
  endfunction

  logic [2:0]       mode;
  logic             is_latch, is_write, is_read;
  wstate_t          state;
  logic [3:0]       addr;
  logic             selected;
  logic [7:0]       wdata;
  logic             commit;
  logic [15:0]      we;
  logic [15:0][7:0] r;
  logic [7:0]       rd_val;

  assign mode     = {bdir, bc2, bc1};
  assign is_latch = (mode == 3'b001) || (mode == 3'b100) || (mode == 3'b111);
  assign is_write = (mode == 3'b110);
  assign is_read  = (mode == 3'b011);

  // Commit uses the pre-edge addr/selected, so a same-cycle LATCH cannot redirect it.
  assign commit = ce && (state == WPEND) && !is_write && selected;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      assign we[gi] = commit && (addr == 4'(gi));
      psg_reg_cell #(.MASK(reg_mask(gi))) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (we[gi]),
        .d     (wdata),
        .q     (r[gi])
      );
    end
  endgenerate

  assign regs = r;

`ifdef PSG_PORTIO_EN
  logic [1:0][7:0] ioa_sync, iob_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ioa_sync <= '0;
      iob_sync <= '0;
    end else if (ce) begin
      ioa_sync <= {ioa_sync[0], ioa_i};
      iob_sync <= {iob_sync[0], iob_i};
    end
  end

  assign ioa_oe = r[7][6];
  assign iob_oe = r[7][7];
  assign ioa_o  = r[14];
  assign iob_o  = r[15];

  // Ports in input mode read the pin state instead of the stored output value.
  always_comb begin
    rd_val = r[addr];
    if (addr == 4'd14 && !r[7][6]) rd_val = ioa_sync[1];
    if (addr == 4'd15 && !r[7][7]) rd_val = iob_sync[1];
  end
`else
  assign rd_val = r[addr];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 4'h0;
      selected    <= 1'b0;
      wdata       <= 8'h00;
      da_o        <= RESET_DOUT;
      da_oe_n     <= 1'b1;
      env_restart <= 1'b0;
    end else if (ce) begin
      if (is_latch) begin
        addr     <= da_i[3:0];
        selected <= (da_i[7:4] == ADDR_HI) && a8 && !a9_n;
      end
      env_restart <= commit && (addr == 4'd13);
      case (state)
        IDLE: if (is_write) begin
          state <= WPEND;
          wdata <= da_i;
        end
        WPEND: if (is_write) wdata <= da_i;
               else          state <= IDLE;
        default: state <= IDLE;
      endcase
      if (is_read && selected) begin
        da_o    <= rd_val;
        da_oe_n <= 1'b0;
      end else begin
        da_oe_n <= 1'b1;
      end
    end
  end

endmodule
